load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-side stage directly downstream of the single-cycle datapath.
//  Inputs: the datapath's ALU result (effective address), its store data
//  (rs2) and the instruction funct3 field.
//  Issues one request per load/store on a valid/ready data bus; asserts
//  stall to freeze the PC while the access is outstanding.
//  Returns aligned, sign- or zero-extended load data for the datapath's
//  memory-read input.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles spent in REQ+WAIT_R before the access is abandoned with an error
// PORTS
//  clk         in   1   clock, rising edge
//  reset_n     in   1   reset, asynchronous, active-low
//  req_valid   in   1   current instruction is a load/store; held high until rsp_valid
//  req_ready   out  1   unit can accept (state==IDLE)
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU: loads only)
//  req_addr    in   32  byte address (ALU result)
//  req_wdata   in   32  store data (rs2)
//  rsp_valid   out  1   one-cycle pulse: access complete
//  rsp_rdata   out  32  extended load data; valid with rsp_valid, else 0
//  rsp_err     out  1   with rsp_valid: timeout / illegal / misaligned
//  stall       out  1   req_valid & ~rsp_valid
//  m_valid     out  1   bus request
//  m_ready     in   1   bus accepts request
//  m_we        out  1   bus write
//  m_addr      out  32  {req_addr[31:2],2'b00}
//  m_be        out  4   byte enables
//  m_wdata     out  32  lane-replicated store data
//  m_rvalid    in   1   bus read data valid
//  m_rdata     in   32  bus read word
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0 except req_ready=1, timeout counter 0.
//  - reset_n low mid-access: m_valid drops immediately; request discarded.
//  - FSM states: IDLE, REQ, WAIT_R, RESP.
//    IDLE->REQ: on req_valid; register we/funct3/addr/wdata.
//    IDLE->RESP: illegal funct3 (011,110,111; or BU/HU with req_we=1).
//      rsp_err=1, no bus access.
//    REQ: m_valid=1, bus fields stable until m_ready.
//      On handshake: store->RESP, load->WAIT_R.
//    WAIT_R: capture on m_rvalid -> RESP.
//      m_rvalid outside WAIT_R is ignored.
//    RESP: rsp_valid=1 for exactly one cycle, then IDLE.
//  - Minimum latency, zero-wait bus (accept = cycle 0):
//    store: rsp_valid in cycle 2. load: rsp_valid in cycle 3.
//  - Timeout: counter clears on IDLE->REQ and increments in REQ/WAIT_R.
//    At TIMEOUT_CYC: ->RESP with rsp_err=1 and rsp_rdata=0; m_valid drops.
//  - Byte enables:
//    B: 4'b0001<<addr[1:0]
//    H: addr[1] ? 4'b1100 : 4'b0011
//    W: 4'b1111
//    m_be=0 for loads.
//  - Write data replicated across lanes: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}.
//  - Loads select the byte/halfword lane by addr[1:0]/addr[1]:
//    B/H sign-extend; BU/HU zero-extend; W passes through.
//  - Back-to-back: IDLE after RESP accepts the next req_valid in the same cycle.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN
//    Defined: H with addr[0]=1, or W with addr[1:0]!=0, goes IDLE->RESP
//      with rsp_err=1, no bus access, rsp_rdata=0.
//    Undefined: the offending low address bits are ignored (forced alignment),
//      the access proceeds normally, rsp_err=0.
// STRUCTURE
//  lsu_pkg: funct3 localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
//    lsu_state_e enum {IDLE,REQ,WAIT_R,RESP}.
//  Sub-module lsu_load_align (combinational):
//    m_rdata + addr[1:0] + funct3 -> extended word.
//    Reused by the later pipelined core.
// TESTING
//  1. SW addr 0x100, wdata 0xA5A5_1234, m_ready=1 ->
//     m_addr=0x100, m_be=1111, rsp_valid cycle 2, stall high cycles 0-1.
//  2. SB addr 0x103, wdata 0x0000_00EE ->
//     m_be=1000, m_wdata=0xEEEE_EEEE.
//  3. LB addr 0x102, m_rdata 0x0080_0000 -> rsp_rdata=0xFFFF_FF80.
//     LBU same address -> 0x0000_0080.
//     LHU addr 0x102, m_rdata 0x8001_0000 -> 0x0000_8001.
//  4. m_ready held 0 with TIMEOUT_CYC=8 ->
//     rsp_valid with rsp_err=1 after 8 REQ cycles; then IDLE, req_ready=1.
//  5. LW addr 0x101 -> with macro: rsp_err=1, m_valid never asserted.
//     Without macro: m_addr=0x100, normal load.
//  6. reset_n low while in WAIT_R -> m_valid=0, rsp_valid=0, state IDLE.
//     Late m_rvalid ignored; next LW completes correctly.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings for the supported access sizes
//   - lsu_state_e: IDLE / REQ / WAIT_R / RESP
//   - helpers that classify a request as illegal or misaligned
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} lsu_state_e;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      LSU_B, LSU_H, LSU_W: return 1'b0;
      LSU_BU, LSU_HU:      return we;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      LSU_H, LSU_HU: return lo[0];
      LSU_W:         return |lo;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the byte/halfword lane addressed by
// addr_lo out of the bus word and sign- or zero-extends it per funct3.
// Ports:
//   rdata   in  32  raw bus read word
//   addr_lo in  2   low address bits of the access
//   funct3  in  3   access size / signedness
//   data    out 32  extended load result (0 for unsupported funct3)
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_l = rdata[7:0];
      2'd1:    byte_l = rdata[15:8];
      2'd2:    byte_l = rdata[23:16];
      default: byte_l = rdata[31:24];
    endcase
    // addr_lo[0] is ignored for halfwords: an unaligned halfword (when not
    // trapped) is forced onto its containing aligned lane.
    half_l = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      LSU_B:   data = {{24{byte_l[7]}}, byte_l};
      LSU_BU:  data = {24'd0, byte_l};
      LSU_H:   data = {{16{half_l[15]}}, half_l};
      LSU_HU:  data = {16'd0, half_l};
      LSU_W:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit sitting after the single-cycle datapath. Turns one
// load/store instruction into one valid/ready bus request, holds the PC via
// stall while outstanding, and returns extended load data.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned H/HU/W
// accesses complete immediately with rsp_err and no bus access; otherwise
// the low address bits are ignored (forced alignment).
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  datapath request
//   rsp_valid/rsp_rdata/rsp_err       one-cycle completion pulse
//   stall                             freeze PC while the access is pending
//   m_valid/m_ready/m_we/m_addr/m_be/m_wdata  bus request channel
//   m_rvalid/m_rdata                  bus read-data return
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e      state, state_nxt;
  logic            we_q, err_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q, wdata_q, rdata_q, load_word;
  logic [CW-1:0]   tcnt;
  logic            bad_req, timeout;

  always_comb begin
    bad_req = f3_illegal(req_funct3, req_we);
`ifdef LSU_MISALIGN_TRAP_EN
    bad_req = bad_req | f3_misaligned(req_funct3, req_addr[1:0]);
`endif
  end

  // Last cycle of the budget: this REQ/WAIT_R cycle is number TIMEOUT_CYC.
  assign timeout = (tcnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    m_valid   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = bad_req ? RESP : REQ;
      end
      REQ: begin
        m_valid = 1'b1;
        if (m_ready)      state_nxt = we_q ? RESP : WAIT_R;
        else if (timeout) state_nxt = RESP;
      end
      WAIT_R: begin
        if (m_rvalid || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= bad_req;
          tcnt    <= '0;
        end
        REQ: begin
          tcnt <= tcnt + CW'(1);
          if (!m_ready && timeout) err_q <= 1'b1;
        end
        WAIT_R: begin
          tcnt <= tcnt + CW'(1);
          if (m_rvalid)     rdata_q <= load_word;
          else if (timeout) err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  lsu_load_align u_align (
    .rdata   (m_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (load_word)
  );

  // Bus fields are only driven while a request is presented.
  always_comb begin
    m_we    = m_valid & we_q;
    m_addr  = m_valid ? {addr_q[31:2], 2'b00} : '0;
    m_be    = '0;
    m_wdata = '0;
    if (m_we) begin
      case (f3_q)
        LSU_B: begin
          m_be    = 4'b0001 << addr_q[1:0];
          m_wdata = {4{wdata_q[7:0]}};
        end
        LSU_H: begin
          m_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          m_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          m_be    = 4'b1111;
          m_wdata = wdata_q;
        end
      endcase
    end
  end

  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;
  assign stall     = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;
  logic        m_valid, m_ready = 1'b1, m_we, m_rvalid = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata = '0;
  logic [3:0]  m_be;

  int passed = 0, total = 0;

  // Results captured by run()
  int          r_lat;
  logic [31:0] r_rd, r_maddr, r_wd;
  logic [3:0]  r_be;
  logic        r_err, r_saw, r_we, r_stall_ok;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
    .m_be(m_be), .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one access starting in the current (IDLE) cycle; m_rvalid is held
  // high throughout, so a load completes as soon as WAIT_R is reached.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] bus_rd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    m_rdata = bus_rd; m_rvalid = 1'b1;
    r_lat = -1; r_saw = 1'b0; r_stall_ok = 1'b1;
    r_rd = '0; r_err = 1'b0; r_maddr = '0; r_be = '0; r_wd = '0; r_we = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid && !r_saw) begin
        r_saw = 1'b1; r_maddr = m_addr; r_be = m_be; r_wd = m_wdata; r_we = m_we;
      end
      if (rsp_valid) begin
        r_lat = c; r_rd = rsp_rdata; r_err = rsp_err;
        if (stall) r_stall_ok = 1'b0;
        break;
      end
      if (!stall) r_stall_ok = 1'b0;
      step();
    end
    step();
    req_valid = 1'b0; m_rvalid = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_m_valid",   m_valid,   1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_stall",     stall,     1'b0);
    chk("rst_m_addr",    m_addr,    32'h0);
    chk("rst_m_be",      m_be,      4'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    step(); reset_n = 1'b1; step();

    // 1. SW
    m_ready = 1'b1;
    run(1'b1, 3'b010, 32'h100, 32'hA5A5_1234, 32'h0);
    chk("sw_lat",   32'(r_lat), 32'd2);
    chk("sw_addr",  r_maddr, 32'h100);
    chk("sw_be",    r_be, 4'b1111);
    chk("sw_wdata", r_wd, 32'hA5A5_1234);
    chk("sw_we",    r_we, 1'b1);
    chk("sw_err",   r_err, 1'b0);
    chk("sw_stall", r_stall_ok, 1'b1);

    // 2. SB / SH lane replication
    run(1'b1, 3'b000, 32'h103, 32'h0000_00EE, 32'h0);
    chk("sb_be",    r_be, 4'b1000);
    chk("sb_wdata", r_wd, 32'hEEEE_EEEE);
    chk("sb_addr",  r_maddr, 32'h100);
    run(1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 32'h0);
    chk("sh_be",    r_be, 4'b1100);
    chk("sh_wdata", r_wd, 32'hBEEF_BEEF);

    // 3. Loads
    run(1'b0, 3'b000, 32'h102, 32'h0, 32'h0080_0000);
    chk("lb_lat",  32'(r_lat), 32'd3);
    chk("lb_data", r_rd, 32'hFFFF_FF80);
    chk("lb_be",   r_be, 4'h0);
    chk("lb_we",   r_we, 1'b0);
    chk("lb_stall", r_stall_ok, 1'b1);
    run(1'b0, 3'b100, 32'h102, 32'h0, 32'h0080_0000);
    chk("lbu_data", r_rd, 32'h0000_0080);
    run(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000);
    chk("lhu_data", r_rd, 32'h0000_8001);
    run(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000);
    chk("lh_data",  r_rd, 32'hFFFF_8001);
    run(1'b0, 3'b010, 32'h104, 32'h0, 32'h1234_5678);
    chk("lw_data",  r_rd, 32'h1234_5678);
    chk("lw_err",   r_err, 1'b0);

    // Illegal funct3 / unsigned store
    run(1'b0, 3'b011, 32'h100, 32'h0, 32'hFFFF_FFFF);
    chk("ill_lat", 32'(r_lat), 32'd1);
    chk("ill_err", r_err, 1'b1);
    chk("ill_bus", r_saw, 1'b0);
    chk("ill_rd",  r_rd, 32'h0);
    run(1'b1, 3'b100, 32'h100, 32'h55, 32'h0);
    chk("sbu_err", r_err, 1'b1);
    chk("sbu_bus", r_saw, 1'b0);

    // 4. Timeout: 8 REQ cycles (1..8), error response in cycle 9
    m_ready = 1'b0;
    run(1'b1, 3'b010, 32'h300, 32'h1, 32'h0);
    chk("to_lat", 32'(r_lat), 32'd9);
    chk("to_err", r_err, 1'b1);
    chk("to_rd",  r_rd, 32'h0);
    chk("to_bus", r_saw, 1'b1);
    @(negedge clk);
    chk("to_idle_ready", req_ready, 1'b1);
    chk("to_idle_mvalid", m_valid, 1'b0);
    step();
    m_ready = 1'b1;

    // 5. Misaligned LW
    run(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", r_err, 1'b1);
    chk("mis_bus", r_saw, 1'b0);
    chk("mis_rd",  r_rd, 32'h0);
    chk("mis_lat", 32'(r_lat), 32'd1);
`else
    chk("mis_addr", r_maddr, 32'h100);
    chk("mis_err",  r_err, 1'b0);
    chk("mis_rd",   r_rd, 32'hCAFE_F00D);
    chk("mis_lat",  32'(r_lat), 32'd3);
`endif

    // Reset while in REQ: m_valid drops immediately
    m_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
    @(negedge clk); step();
    @(negedge clk);
    chk("rq_mvalid_before", m_valid, 1'b1);
    reset_n = 1'b0; #1;
    chk("rq_mvalid_rst", m_valid, 1'b0);
    req_valid = 1'b0;
    step(); reset_n = 1'b1; step();

    // 6. Reset while in WAIT_R
    m_ready = 1'b1; m_rvalid = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
    @(negedge clk); step();        // cycle 1: REQ
    @(negedge clk); step();        // cycle 2: WAIT_R
    @(negedge clk);
    chk("wr_mvalid", m_valid, 1'b0);
    chk("wr_stall",  stall, 1'b1);
    reset_n = 1'b0; #1;
    chk("wr_rst_mvalid", m_valid, 1'b0);
    chk("wr_rst_rsp",    rsp_valid, 1'b0);
    chk("wr_rst_ready",  req_ready, 1'b1);
    req_valid = 1'b0;
    step(); reset_n = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;   // late return
    @(negedge clk);
    chk("late_rsp", rsp_valid, 1'b0);
    step(); m_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rsp2",  rsp_valid, 1'b0);
    chk("late_ready", req_ready, 1'b1);
    step();
    run(1'b0, 3'b010, 32'h204, 32'h0, 32'h0BAD_F00D);
    chk("post_lw_data", r_rd, 32'h0BAD_F00D);
    chk("post_lw_addr", r_maddr, 32'h204);
    chk("post_lw_lat",  32'(r_lat), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
